load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 38 +++
 rtl/lsu_byte_lane.sv | 36 +++
 rtl/load_store_unit.sv | 118 +++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: request opcodes, FSM states,
// the default decoded address width and small opcode helpers.
package lsu_pkg;

    localparam int MEM_ADDR_BITS_DEFAULT = 14;

    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LH  = 3'd1,
        OP_LW  = 3'd2,
        OP_SB  = 3'd3,
        OP_LBU = 3'd4,
        OP_LHU = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } lsu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } lsu_state_e;

    function automatic logic op_is_load(input lsu_op_e op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction

    function automatic logic op_misaligned(input lsu_op_e op, input logic [1:0] lo);
        case (op)
            OP_LH, OP_LHU, OP_SH: return lo[0];
            OP_LW, OP_SW:         return lo != 2'b00;
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational lane logic: extracts and extends load data from a memory
// word, and merges store data into a word for read-modify-write.
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  lsu_op_e     op,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Little-endian lanes: byte k at word[8k+7:8k], halfword h at word[16h+15:16h].
    always_comb begin
        byte_sel   = word[{offset, 3'b000} +: 8];
        half_sel   = offset[1] ? word[31:16] : word[15:0];
        load_data  = '0;
        store_word = word;
        case (op)
            OP_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU: load_data = {24'h0, byte_sel};
            OP_LH:  load_data = {{16{half_sel[15]}}, half_sel};
            OP_LHU: load_data = {16'h0, half_sel};
            OP_LW:  load_data = word;
            OP_SB:  store_word[{offset, 3'b000} +: 8] = wdata[7:0];
            OP_SH:  store_word[{offset[1], 4'b0000} +: 16] = wdata[15:0];
            OP_SW:  store_word = wdata;
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request at a time, runs it against a
// registered-read data memory and returns a single-cycle response.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_ADDR_BITS = MEM_ADDR_BITS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  state;
    lsu_op_e     op_q;
    logic [1:0]  offset_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;
    logic        err_q;
    logic [31:0] load_data;
    logic [31:0] store_word;
    lsu_op_e     req_op_e;
    logic        req_bad;

    assign req_op_e = lsu_op_e'(req_op);
    assign req_bad  = op_misaligned(req_op_e, req_addr[1:0])
                    || ((req_addr >> MEM_ADDR_BITS) != 32'd0);

    lsu_byte_lane u_lane (
        .op         (op_q),
        .offset     (offset_q),
        .word       (word_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    // Lane results are only exposed in the states that own them, so both
    // buses read as zero everywhere else without extra registers.
    assign req_ready  = (state == ST_IDLE);
    assign mem_wdata  = (state == ST_WR) ? store_word : '0;
    assign resp_rdata = (state == ST_RESP && !err_q) ? load_data : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            op_q       <= OP_LB;
            offset_q   <= '0;
            wdata_q    <= '0;
            word_q     <= '0;
            err_q      <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q     <= req_op_e;
                        offset_q <= req_addr[1:0];
                        wdata_q  <= req_wdata;
                        word_q   <= '0;
                        err_q    <= req_bad;
                        if (req_bad) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else if (req_op_e == OP_SW) begin
                            state     <= ST_WR;
                            mem_write <= 1'b1;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                        end else begin
                            state    <= ST_RD;
                            mem_read <= 1'b1;
                            mem_addr <= {req_addr[31:2], 2'b00};
                        end
                    end
                end
                ST_RD: state <= ST_CAP;
                // Sub-word stores fall through to WR to merge into the captured word.
                ST_CAP: begin
                    word_q <= mem_rdata;
                    if (op_is_load(op_q)) begin
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                    end else begin
                        state     <= ST_WR;
                        mem_write <= 1'b1;
                    end
                end
                ST_WR: begin
                    state      <= ST_RESP;
                    resp_valid <= 1'b1;
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
